exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage directly downstream of the 4-entry, 32-bit register file.
- Consumes the two read operands (ReadData1/ReadData2) plus an opcode and destination register.
- Computes a result and drives the write-back triple (wb_reg / wb_data / wb_en) that feeds the register file's WriteReg / WriteData / RegWrite.
- Single-cycle ALU ops plus an iterative multi-cycle multiply, with a valid/ready issue handshake.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 2, register address width (4 registers).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept an issue this cycle.
- op  in  3  operation code.
- dest  in  ADDR_W  destination register.
- src_a  in  DATA_W  operand A (from ReadData1).
- src_b  in  DATA_W  operand B (from ReadData2).
- wb_en  out  1  write-back strobe (to RegWrite).
- wb_reg  out  ADDR_W  write-back register (to WriteReg).
- wb_data  out  DATA_W  write-back value (to WriteData).
- wb_zero  out  1  wb_data == 0, valid with wb_en.
- busy  out  1  multiply in progress.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low. While reset=0:
  - state=IDLE;
  - wb_en, wb_reg, wb_data, wb_zero, busy are all 0;
  - in_ready=0.
- After reset deasserts, in_ready=1.
- Issue: accepted on a rising edge where in_valid=1 and in_ready=1. in_ready = (state==IDLE) and reset=1.
- Opcodes:
  - 000 ADD: wraps mod 2^DATA_W.
  - 001 SUB: A−B, wraps.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed compare, result 1 or 0, zero-extended.
  - 110 MUL: low DATA_W bits of the unsigned product.
  - 111 reserved: accepted, no write-back.
- ALU ops (000–101):
  - Result registered at the accept edge. wb_en=1 for exactly the following cycle, with wb_reg=dest and wb_data=result.
  - State stays IDLE, so back-to-back issues give one write-back per cycle.
- wb_en is a one-cycle pulse. It deasserts at the next edge unless a new ALU op is accepted on that edge.
- wb_reg and wb_data hold their last values while wb_en=0.
- States: IDLE, MUL.
  - IDLE → MUL on accepting op 110.
  - MUL → IDLE after DATA_W iterations.
- MUL sequencing:
  - At accept: latch A, B and dest; clear the accumulator; load the iteration counter with 0.
  - Each cycle in MUL: if B[0], acc += A; then A <<= 1, B >>= 1, counter++.
  - When counter reaches DATA_W−1, that edge returns to IDLE with the final accumulator driven on wb_data and wb_en=1.
- MUL timing, for accept on edge k:
  - wb_en high between edges k+DATA_W and k+DATA_W+1.
  - busy=1 and in_ready=0 from edge k to edge k+DATA_W.
  - in_ready returns to 1 in the same cycle wb_en pulses, so a new op may be accepted on edge k+DATA_W+1.
- Operands are latched at accept. Changes to src_a/src_b/dest during MUL are ignored.
- in_valid while in_ready=0: ignored, no side effects. The upstream must hold the request.
- Reset mid-MUL: the operation is aborted, with no wb_en pulse, ever, for the aborted op.
- Reserved op 111: consumes the issue slot, wb_en stays 0, state unchanged.
- wb_zero is registered with the result and meaningful only when wb_en=1.

Decomposition:
- exec_defs.vh (shared include) holds:
  - opcode constants OP_ADD…OP_RSV;
  - state encodings S_IDLE/S_MUL;
  - default widths.
- Sub-module mul_seq: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - Holds the counter and accumulator.
- exec_unit holds the handshake, ALU and write-back mux.

Test Plan:
- Reset then ADD: reset=0 for 12 ns → all outputs 0 and in_ready=0. After release, issue op=000, src_a=0xAFAFDEDE, src_b=0x00000001, dest=2'b10 → next cycle wb_en=1, wb_reg=2'b10, wb_data=0xAFAFDEDF, wb_zero=0.
- Back-to-back ALU issues on consecutive edges:
  - SUB 0x5−0x7 → 0xFFFFFFFE;
  - XOR 0xCCCCDDDD^0xCCCCDDDD → 0x00000000 with wb_zero=1;
  - SLT 0x80000000 vs 0x00000001 → 0x00000001.
  - Expect three consecutive wb_en cycles, in order.
- MUL: op=110, src_a=0x0000FFFF, src_b=0x00010001, dest=2'b11 →
  - busy=1 and in_ready=0 for 32 cycles;
  - in_valid asserted during MUL is ignored;
  - wb_en pulses once with wb_data=0xFFFFFFFF and wb_reg=2'b11 exactly 32 cycles after accept.
- Reset mid-MUL: start MUL 0x3×0x4, assert reset=0 at iteration 10 for one cycle → no wb_en pulse afterwards, in_ready=1 after release, and a following ADD 0x1+0x1 → 0x2.
- Reserved op: issue op=111 with dest=2'b01 → wb_en stays 0 for 3 cycles, in_ready stays 1, and the next ADD completes normally.
- Loopback: connect to the register file. ADD 0xBBBBBBBB+0 into reg 2'b11, then read reg 2'b11 → ReadData reads 0xBBBBBBBB after the write-back edge.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared opcodes, FSM encodings and default widths for the execute stage.
package exec_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles.
module mul_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, acc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    always_comb begin
        acc_step = acc_q + (b_q[0] ? a_q : '0);
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = acc_step;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) run_d = 1'b0;
        end
    end

    // product is the post-iteration accumulator so the final step lands on the done edge
    assign done    = run_q && (cnt_q == LAST);
    assign product = acc_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative multiply, driving the register-file write-back port.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              wb_en_q, wb_en_d, wb_zero_q, wb_zero_d;
    logic [ADDR_W-1:0] wb_reg_q, wb_reg_d, mul_dest_q, mul_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d, alu_res, mul_prod;
    logic              accept, mul_start, mul_done, slt;

    assign in_ready = reset && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_MUL);
    assign slt      = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu_res = '0;
        unique case (op_e'(op))
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
            OP_MUL:  alu_res = '0;
            OP_RSV:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d    = state_q;
        wb_en_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        mul_dest_d = mul_dest_q;
        mul_start  = 1'b0;
        if (accept) begin
            if (op == OP_MUL) begin
                state_d    = S_MUL;
                mul_start  = 1'b1;
                mul_dest_d = dest;
            end else if (op != OP_RSV) begin
                wb_en_d   = 1'b1;
                wb_reg_d  = dest;
                wb_data_d = alu_res;
                wb_zero_d = (alu_res == '0);
            end
        end
        // accept can only occur in IDLE, so this never collides with an ALU write-back
        if (state_q == S_MUL && mul_done) begin
            state_d   = S_IDLE;
            wb_en_d   = 1'b1;
            wb_reg_d  = mul_dest_q;
            wb_data_d = mul_prod;
            wb_zero_d = (mul_prod == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b0;
            mul_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
            mul_dest_q <= mul_dest_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_reg  = wb_reg_q;
    assign wb_data = wb_data_q;
    assign wb_zero = wb_zero_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 4x32 register file on the write-back port.
module tb_exec_unit;

    logic        clk, reset, in_valid, in_ready;
    logic [2:0]  op;
    logic [1:0]  dest;
    logic [31:0] src_a, src_b;
    logic        wb_en, wb_zero, busy;
    logic [1:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] rf [4];

    int n_chk  = 0;
    int n_pass = 0;

    exec_unit #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dest(dest), .src_a(src_a), .src_b(src_b),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_zero(wb_zero), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (wb_en) rf[wb_reg] <= wb_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] d);
        in_valid = 1'b1; op = o; src_a = a; src_b = b; dest = d;
    endtask

    initial begin
        int busy_cnt, rdy_cnt, wb_cnt;
        reset = 1'b0; in_valid = 1'b0; op = 3'b000; dest = 2'b00; src_a = '0; src_b = '0;

        // reset state
        #12;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_zero", 32'(wb_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); reset = 1'b1;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ADD
        @(negedge clk); drive(3'b000, 32'hAFAFDEDE, 32'h1, 2'b10);
        @(negedge clk); in_valid = 1'b0;
        chk("add_wb_en", 32'(wb_en), 32'd1);
        chk("add_wb_reg", 32'(wb_reg), 32'd2);
        chk("add_wb_data", wb_data, 32'hAFAFDEDF);
        chk("add_wb_zero", 32'(wb_zero), 32'd0);
        @(negedge clk);
        chk("add_wb_en_drop", 32'(wb_en), 32'd0);
        chk("add_wb_data_hold", wb_data, 32'hAFAFDEDF);

        // back-to-back SUB, XOR, SLT
        drive(3'b001, 32'h5, 32'h7, 2'b00);
        @(negedge clk);
        chk("sub_wb_en", 32'(wb_en), 32'd1);
        chk("sub_wb_reg", 32'(wb_reg), 32'd0);
        chk("sub_wb_data", wb_data, 32'hFFFFFFFE);
        drive(3'b100, 32'hCCCCDDDD, 32'hCCCCDDDD, 2'b01);
        @(negedge clk);
        chk("xor_wb_en", 32'(wb_en), 32'd1);
        chk("xor_wb_reg", 32'(wb_reg), 32'd1);
        chk("xor_wb_data", wb_data, 32'h0);
        chk("xor_wb_zero", 32'(wb_zero), 32'd1);
        drive(3'b101, 32'h80000000, 32'h1, 2'b10);
        @(negedge clk); in_valid = 1'b0;
        chk("slt_wb_en", 32'(wb_en), 32'd1);
        chk("slt_wb_data", wb_data, 32'h1);
        chk("slt_wb_zero", 32'(wb_zero), 32'd0);
        @(negedge clk);
        chk("b2b_wb_en_drop", 32'(wb_en), 32'd0);

        // MUL with an ignored request held during the multiply
        drive(3'b110, 32'h0000FFFF, 32'h00010001, 2'b11);
        busy_cnt = 0; rdy_cnt = 0; wb_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i < 31) drive(3'b000, 32'h12345678, 32'h1, 2'b00);
            else in_valid = 1'b0;
            busy_cnt += int'(busy);
            rdy_cnt  += int'(in_ready);
            wb_cnt   += int'(wb_en);
        end
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("mul_ready_low", 32'(rdy_cnt), 32'd0);
        chk("mul_no_early_wb", 32'(wb_cnt), 32'd0);
        @(negedge clk);
        chk("mul_wb_en", 32'(wb_en), 32'd1);
        chk("mul_wb_reg", 32'(wb_reg), 32'd3);
        chk("mul_wb_data", wb_data, 32'hFFFFFFFF);
        chk("mul_ready_back", 32'(in_ready), 32'd1);
        chk("mul_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("mul_single_pulse", 32'(wb_en), 32'd0);

        // reset during MUL aborts it
        drive(3'b110, 32'h3, 32'h4, 2'b01);
        @(negedge clk); in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1 chk("abort_in_ready", 32'(in_ready), 32'd1);
        wb_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            wb_cnt += int'(wb_en);
        end
        chk("abort_no_wb", 32'(wb_cnt), 32'd0);
        drive(3'b000, 32'h1, 32'h1, 2'b00);
        @(negedge clk); in_valid = 1'b0;
        chk("abort_add_wb_en", 32'(wb_en), 32'd1);
        chk("abort_add_data", wb_data, 32'h2);

        // reserved opcode
        @(negedge clk);
        drive(3'b111, 32'hDEADBEEF, 32'h1, 2'b01);
        @(negedge clk); in_valid = 1'b0;
        wb_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            wb_cnt  += int'(wb_en);
            rdy_cnt += int'(in_ready);
        end
        chk("rsv_no_wb", 32'(wb_cnt), 32'd0);
        chk("rsv_ready", 32'(rdy_cnt), 32'd3);
        drive(3'b000, 32'h5, 32'h6, 2'b01);
        @(negedge clk); in_valid = 1'b0;
        chk("rsv_add_wb_en", 32'(wb_en), 32'd1);
        chk("rsv_add_reg", 32'(wb_reg), 32'd1);
        chk("rsv_add_data", wb_data, 32'hB);

        // loopback through the register file
        @(negedge clk);
        drive(3'b000, 32'hBBBBBBBB, 32'h0, 2'b11);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("loopback_rf3", rf[3], 32'hBBBBBBBB);
        chk("loopback_rf1", rf[1], 32'hB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
